xgcd_apb_initiator: RTL and testbench
=====================================

Name: xgcd_apb_initiator

Overview:
- APB3 requester (initiator). Converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns each result on a valid/ready response stream.
- Drives the APB completer ports of the XGCD cores and the RO block from an on-chip controller or test sequencer.
- One transfer in flight at a time; no pipelining across transfers.

Parameters:
- ADDR_WIDTH, 32, width of CMD_ADDR and PADDR
- DATA_WIDTH, 32, width of write data, PRDATA and RSP_RDATA
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit in cycles; used only when APB_TIMEOUT_EN is defined; legal range 1..65535

Ports:
- CLK  in  1  single clock for all logic
- RESET  in  1  asynchronous reset, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted this cycle when high together with CMD_VALID
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_WIDTH  transfer address
- CMD_WDATA  in  DATA_WIDTH  write data
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes
- RSP_ERR  out  1  PSLVERR seen, or timeout
- RSP_TIMEOUT  out  1  transfer ended by timeout
- PADDR  out  ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB completer error
- BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs 0 except CMD_READY, which reflects IDLE and is therefore 1.
- Reset mid-transfer: PSEL and PENABLE drop with no completion, any pending response is discarded, and no RSP_VALID follows.
- All outputs are registered, except CMD_READY, which is decoded from state (CMD_READY = IDLE).
- IDLE:
  - CMD_VALID & CMD_READY latches CMD_WRITE, CMD_ADDR and CMD_WDATA into PWRITE, PADDR and PWDATA.
  - Next state is SETUP.
- SETUP (exactly 1 cycle): PSEL = 1, PENABLE = 0. Next state is ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS.
  - Stays in ACCESS while PREADY = 0.
  - On the PREADY = 1 edge:
    - RSP_RDATA captures PRDATA for reads and 0 for writes.
    - RSP_ERR captures PSLVERR, for both reads and writes.
    - Next state is RESP; PSEL and PENABLE are 0 from the next cycle.
  - PRDATA and PSLVERR are ignored whenever PREADY = 0.
- RESP:
  - RSP_VALID = 1 with RSP_RDATA, RSP_ERR and RSP_TIMEOUT held stable until RSP_READY.
  - On RSP_VALID & RSP_READY: RSP_VALID drops next cycle and next state is IDLE.
- Minimum latency: command accepted at cycle 0 → PSEL at 1 → PENABLE at 2 → with PREADY = 1 at 2, RSP_VALID at 3 → earliest next acceptance at 4.
- CMD_VALID while not IDLE: stalled by CMD_READY = 0. The command need not remain stable, since nothing is sampled until IDLE.
- Idle values: PADDR, PWRITE and PWDATA hold their last values when idle; they are don't-care because PSEL = 0.
- PSEL and PENABLE are never high outside SETUP/ACCESS. PENABLE is never high without PSEL.
- No internal address decode or range check; every address is forwarded as-is.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: the transfer is abandoned, PSEL and PENABLE drop next cycle, and the state moves to RESP with RSP_ERR = 1, RSP_TIMEOUT = 1 and RSP_RDATA = 0.
  - PREADY = 1 in the same cycle the count reaches TIMEOUT_CYCLES means normal completion, not a timeout.
- Undefined: no counter is built, ACCESS waits indefinitely, and RSP_TIMEOUT is tied 0.

Decomposition:
- Package xgcd_apb_pkg contains:
  - the state enum {IDLE, SETUP, ACCESS, RESP} (2 bits);
  - APB_ADDR_W = 32 and APB_DATA_W = 32;
  - the timeout counter width constant (16).
- One sub-module, apb_wait_timer: counter, clear, increment and terminal compare. It is instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write, zero wait states: CMD write addr 0x0000_0010, data 0xDEAD_BEEF; PREADY = 1 → PSEL at cycle 1, PENABLE at cycle 2, PWDATA = 0xDEAD_BEEF stable through both; RSP_VALID at cycle 3 with RSP_ERR = 0 and RSP_RDATA = 0.
- Read, 3 wait states: read addr 0x0000_0004; PREADY low 3 ACCESS cycles, then high with PRDATA = 0x1234_5678 → PENABLE held 4 cycles, PADDR stable, RSP_RDATA = 0x1234_5678.
- Error plus response backpressure: PSLVERR = 1 with PREADY; RSP_READY held low 5 cycles → RSP_ERR = 1, RSP_VALID held 5 cycles with data stable, CMD_READY = 0 throughout, BUSY = 1.
- Back-to-back commands: CMD_VALID held with 2 queued commands → second accepted exactly 1 cycle after the first response handshake; no PSEL overlap between transfers.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): PREADY held 0 → PSEL low after 8 wait cycles, RSP_ERR = 1, RSP_TIMEOUT = 1. Without the macro, same stimulus → still in ACCESS after 1000 cycles.
- Reset mid-ACCESS: RESET asserted during ACCESS → PSEL, PENABLE and RSP_VALID are 0 immediately and CMD_READY = 1 after release; no spurious response.

Source files
------------

// File: rtl/xgcd_apb_pkg.sv
// -----------------------------------------------------------------------------
// xgcd_apb_pkg
// Shared types and constants for the XGCD APB3 initiator.
//   apb_state_t  : transfer FSM states (IDLE, SETUP, ACCESS, RESP), 2 bits
//   APB_ADDR_W   : default APB address width
//   APB_DATA_W   : default APB data width
//   TMO_CNT_W    : width of the ACCESS-phase wait counter
// -----------------------------------------------------------------------------
package xgcd_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int TMO_CNT_W  = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles spent waiting on PREADY and flags the cycle in which
// the count reaches LIMIT.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count (asserted the cycle before ACCESS is entered)
//   inc      : one more wait cycle (ACCESS with PREADY low)
//   expire   : this wait cycle is the LIMIT-th one; transfer should abandon
// -----------------------------------------------------------------------------
module apb_wait_timer
    import xgcd_apb_pkg::*;
#(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [TMO_CNT_W-1:0] TERM = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds the number of earlier wait cycles, so the LIMIT-th wait
    // cycle is the one where cnt_q == LIMIT-1 and another increment arrives.
    assign expire = inc && (cnt_q == TERM);

endmodule

// File: rtl/xgcd_apb_initiator.sv
// -----------------------------------------------------------------------------
// xgcd_apb_initiator
// APB3 requester: turns a valid/ready command stream into one SETUP/ACCESS
// transfer at a time and returns the result on a valid/ready response stream.
// Optional macro APB_TIMEOUT_EN: abandon ACCESS after TIMEOUT_CYCLES wait
// cycles and report RSP_ERR=1, RSP_TIMEOUT=1. Without it ACCESS waits forever.
// Ports:
//   CLK, RESET                       clock, asynchronous active-high reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA command stream (READY = state is IDLE)
//   RSP_VALID/READY/RDATA/ERR/TIMEOUT response stream
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB requester outputs
//   PRDATA/PREADY/PSLVERR            APB completer inputs
//   BUSY                             state is not IDLE
// All outputs are registered except CMD_READY.
// -----------------------------------------------------------------------------
module xgcd_apb_initiator
    import xgcd_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY
);

    apb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  busy_q, busy_d;
    logic                  timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (state_q == SETUP),
        .inc    ((state_q == ACCESS) && !PREADY),
        .expire (timeout_hit)
    );
`else
    // Always 0; the parameter is folded in only so it stays referenced.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    paddr_d  = CMD_ADDR;
                    pwdata_d = CMD_WDATA;
                    pwrite_d = CMD_WRITE;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign CMD_READY   = (state_q == IDLE);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_xgcd_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_xgcd_apb_initiator
// Directed scenarios with literal expectations, then randomized traffic, all
// watched every cycle by a transaction-level model of the initiator.
// -----------------------------------------------------------------------------
module tb_xgcd_apb_initiator;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic          CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [DW-1:0] CMD_WDATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic          RSP_TIMEOUT;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b1;
    logic          PSLVERR = 1'b0;
    logic          BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    xgcd_apb_initiator #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_ERR     (RSP_ERR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // m_xfer : a transfer is on the bus; m_t counts its cycles (1 = SETUP,
    // >=2 = ACCESS); m_w counts ACCESS cycles that saw PREADY low.
    bit          m_xfer = 0, m_resp = 0;
    int          m_t = 0, m_w = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic          m_write = 0, m_err = 0, m_tmo = 0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_xfer <= 0; m_resp <= 0; m_t <= 0; m_w <= 0;
            m_rdata <= '0; m_err <= 0; m_tmo <= 0;
        end else if (m_resp) begin
            if (RSP_READY) m_resp <= 0;
        end else if (m_xfer) begin
            if (m_t < 2) m_t <= m_t + 1;
            else if (PREADY) begin
                m_xfer <= 0; m_resp <= 1;
                m_rdata <= m_write ? '0 : PRDATA;
                m_err <= PSLVERR; m_tmo <= 0;
            end
`ifdef APB_TIMEOUT_EN
            else if (m_w == TMO - 1) begin
                m_xfer <= 0; m_resp <= 1;
                m_rdata <= '0; m_err <= 1; m_tmo <= 1;
            end
`endif
            else begin
                m_t <= m_t + 1; m_w <= m_w + 1;
            end
        end else if (CMD_VALID) begin
            m_xfer <= 1; m_t <= 1; m_w <= 0;
            m_addr <= CMD_ADDR; m_wdata <= CMD_WDATA; m_write <= CMD_WRITE;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        chk("cmd_ready", CMD_READY, !m_xfer && !m_resp);
        chk("psel", PSEL, m_xfer);
        chk("penable", PENABLE, m_xfer && m_t >= 2);
        chk("busy", BUSY, m_xfer || m_resp);
        chk("rsp_valid", RSP_VALID, m_resp);
        if (m_xfer) begin
            chk("paddr", PADDR, m_addr);
            chk("pwrite", PWRITE, m_write);
            chk("pwdata", PWDATA, m_wdata);
        end
        if (m_resp) begin
            chk("rsp_rdata", RSP_RDATA, m_rdata);
            chk("rsp_err", RSP_ERR, m_err);
            chk("rsp_timeout", RSP_TIMEOUT, m_tmo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d;
    endtask

    task automatic drain();
        int k;
        CMD_VALID = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; RSP_READY = 1'b1;
        k = 0;
        while (!(CMD_READY && !RSP_VALID) && k < 50) begin
            step(); k++;
        end
        chk("drain_bound", k < 50, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pen_cnt, vld_cnt, hs, acc2, n_acc;

        // reset state
        step(); step();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_cmd_ready", CMD_READY, 1'b1);
        chk("rst_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_busy", BUSY, 1'b0);
        RESET = 1'b0;
        step();

        // write, zero wait states
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        PREADY = 1'b1; RSP_READY = 1'b1;
        step(); CMD_VALID = 1'b0;
        chk("w0_c1_psel", PSEL, 1'b1);
        chk("w0_c1_penable", PENABLE, 1'b0);
        chk("w0_c1_pwdata", PWDATA, 32'hDEAD_BEEF);
        step();
        chk("w0_c2_penable", PENABLE, 1'b1);
        chk("w0_c2_pwdata", PWDATA, 32'hDEAD_BEEF);
        step();
        chk("w0_c3_rsp_valid", RSP_VALID, 1'b1);
        chk("w0_c3_rsp_err", RSP_ERR, 1'b0);
        chk("w0_c3_rsp_rdata", RSP_RDATA, 32'h0);
        chk("w0_c3_psel", PSEL, 1'b0);
        step();
        chk("w0_c4_cmd_ready", CMD_READY, 1'b1);

        // read, 3 wait states
        send(1'b0, 32'h0000_0004, 32'h0);
        PREADY = 1'b0;
        pen_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            CMD_VALID = 1'b0;
            if (PENABLE) begin
                pen_cnt++;
                chk("r3_paddr", PADDR, 32'h0000_0004);
            end
            if (c == 5) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
        end
        chk("r3_penable_cycles", pen_cnt, 4);
        chk("r3_rsp_valid", RSP_VALID, 1'b1);
        chk("r3_rsp_rdata", RSP_RDATA, 32'h1234_5678);
        drain();

        // error with response backpressure
        send(1'b1, 32'h0000_0020, 32'h5555_AAAA);
        PREADY = 1'b1; PSLVERR = 1'b1; RSP_READY = 1'b0;
        step(); CMD_VALID = 1'b0;
        step(); step();
        vld_cnt = 0;
        for (int c = 3; c <= 8; c++) begin
            if (RSP_VALID) begin
                vld_cnt++;
                chk("err_rsp_err", RSP_ERR, 1'b1);
                chk("err_cmd_ready", CMD_READY, 1'b0);
                chk("err_busy", BUSY, 1'b1);
            end
            if (c == 7) RSP_READY = 1'b1;
            step();
        end
        chk("err_valid_cycles", vld_cnt, 5);
        drain();

        // back-to-back commands
        send(1'b0, 32'h0000_0100, 32'h0);
        PREADY = 1'b1; PRDATA = 32'hCAFE_0001; RSP_READY = 1'b1;
        hs = -1; acc2 = -1; n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (CMD_VALID && CMD_READY) begin
                n_acc++;
                if (n_acc == 2) acc2 = c;
            end
            if (RSP_VALID && RSP_READY && hs < 0) hs = c;
            step();
            if (n_acc == 1) CMD_ADDR = 32'h0000_0104;
            if (n_acc == 2) CMD_VALID = 1'b0;
        end
        chk("b2b_handshake_cycle", hs, 3);
        chk("b2b_second_accept", acc2, hs + 1);
        drain();

        // PREADY held low
        send(1'b0, 32'h0000_0008, 32'h0);
        PREADY = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            step();
            CMD_VALID = 1'b0;
        end
        chk("tmo_psel", PSEL, 1'b0);
        chk("tmo_rsp_valid", RSP_VALID, 1'b1);
        chk("tmo_rsp_err", RSP_ERR, 1'b1);
        chk("tmo_rsp_timeout", RSP_TIMEOUT, 1'b1);
`else
        for (int c = 1; c <= 1000; c++) begin
            step();
            CMD_VALID = 1'b0;
        end
        chk("notmo_psel", PSEL, 1'b1);
        chk("notmo_penable", PENABLE, 1'b1);
        chk("notmo_rsp_valid", RSP_VALID, 1'b0);
`endif
        drain();

        // reset mid-ACCESS
        send(1'b1, 32'h0000_0030, 32'h0BAD_F00D);
        PREADY = 1'b0;
        step(); CMD_VALID = 1'b0;
        step(); step();
        chk("mid_penable_before", PENABLE, 1'b1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_psel", PSEL, 1'b0);
        chk("mid_rst_penable", PENABLE, 1'b0);
        chk("mid_rst_rsp_valid", RSP_VALID, 1'b0);
        step(); step();
        RESET = 1'b0; PREADY = 1'b1;
        step();
        chk("mid_cmd_ready", CMD_READY, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("mid_no_rsp", RSP_VALID, 1'b0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            CMD_VALID = ($urandom_range(0, 1) == 1);
            CMD_WRITE = $urandom_range(0, 1);
            CMD_ADDR  = $urandom;
            CMD_WDATA = $urandom;
            PREADY    = ($urandom_range(0, 2) != 0);
            PSLVERR   = ($urandom_range(0, 3) == 0);
            PRDATA    = $urandom;
            RSP_READY = ($urandom_range(0, 1) == 1);
            step();
        end
        drain();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
